// File: rtl/spi_out.sv
// spi_out: SPI mode-0 frame writer; sends a start address then word_count payload words, MSB first.
// Define SPI_OUT_READBACK_EN to add MISO capture (read_data / read_strobe) during payload words.
module spi_out #(
    parameter int unsigned ADDRESS_BUS_WIDTH = 16,
    parameter int unsigned DATA_BUS_WIDTH    = 16,
    parameter int unsigned CLK_DIV           = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
    input  logic [ADDRESS_BUS_WIDTH-1:0] word_count,
    input  logic [DATA_BUS_WIDTH-1:0]    word_data,
    input  logic                         word_valid,
    output logic                         word_ready,
    output logic                         busy,
    output logic                         done_strobe,
    output logic                         cs,
    output logic                         sck,
    output logic                         mosi,
    input  logic                         miso
`ifdef SPI_OUT_READBACK_EN
    ,
    output logic [DATA_BUS_WIDTH-1:0]    read_data,
    output logic                         read_strobe
`endif
);

    localparam int unsigned ShiftW = (ADDRESS_BUS_WIDTH > DATA_BUS_WIDTH) ?
                                     ADDRESS_BUS_WIDTH : DATA_BUS_WIDTH;
    localparam int unsigned BitW   = $clog2(ShiftW) + 1;
    localparam int unsigned DivW   = $clog2(CLK_DIV) + 1;

    typedef enum logic [2:0] {StIdle, StSetup, StAddr, StFetch, StData, StHold} state_e;

    state_e                         state_q, state_d;
    logic [DivW-1:0]                div_q, div_d;
    logic [BitW-1:0]                bit_q, bit_d;
    logic [ShiftW-1:0]              shift_q, shift_d;
    logic [ADDRESS_BUS_WIDTH-1:0]   cnt_q, cnt_d;
    logic                           sck_q, sck_d;
    logic                           cs_q, cs_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           div_last;

`ifdef SPI_OUT_READBACK_EN
    logic [DATA_BUS_WIDTH-1:0]      rx_q, rx_d;
    logic [DATA_BUS_WIDTH-1:0]      rdata_q, rdata_d;
    logic                           rstb_q, rstb_d;

    assign read_data   = rdata_q;
    assign read_strobe = rstb_q;
`else
    logic unused_miso;
    assign unused_miso = miso;
`endif

    assign div_last    = (div_q == DivW'(CLK_DIV - 1));
    assign word_ready  = (state_q == StFetch);
    assign busy        = busy_q;
    assign done_strobe = done_q;
    assign cs          = cs_q;
    assign sck         = sck_q;
    // Address and data are left-justified in the shifter so the MSB always drives mosi.
    assign mosi        = shift_q[ShiftW-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_OUT_READBACK_EN
            rx_q    <= '0;
            rdata_q <= '0;
            rstb_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SPI_OUT_READBACK_EN
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            rstb_q  <= rstb_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sck_d   = sck_q;
        cs_d    = cs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SPI_OUT_READBACK_EN
        rx_d    = rx_q;
        rdata_d = rdata_q;
        rstb_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (word_count != '0) begin
                        state_d = StSetup;
                        cs_d    = 1'b0;
                        busy_d  = 1'b1;
                        shift_d = ShiftW'(start_address) << (ShiftW - ADDRESS_BUS_WIDTH);
                        cnt_d   = word_count;
                        div_d   = '0;
                        bit_d   = '0;
                        sck_d   = 1'b0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = StAddr;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StAddr, StData: begin
                if (!div_last) begin
                    div_d = div_q + 1'b1;
                end else if (!sck_q) begin
                    div_d = '0;
                    sck_d = 1'b1;
`ifdef SPI_OUT_READBACK_EN
                    if (state_q == StData) begin
                        rx_d = DATA_BUS_WIDTH'({rx_q, miso});
                    end
`endif
                end else begin
                    // Falling edge: the only point where mosi advances within a bit stream.
                    div_d   = '0;
                    sck_d   = 1'b0;
                    shift_d = shift_q << 1;
                    bit_d   = bit_q + 1'b1;
                    if (state_q == StAddr && bit_q == BitW'(ADDRESS_BUS_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = StFetch;
                    end else if (state_q == StData && bit_q == BitW'(DATA_BUS_WIDTH - 1)) begin
                        bit_d   = '0;
                        cnt_d   = cnt_q - 1'b1;
                        state_d = (cnt_q == ADDRESS_BUS_WIDTH'(1)) ? StHold : StFetch;
`ifdef SPI_OUT_READBACK_EN
                        rdata_d = rx_q;
                        rstb_d  = 1'b1;
`endif
                    end
                end
            end
            StFetch: begin
                if (word_valid) begin
                    shift_d = ShiftW'(word_data) << (ShiftW - DATA_BUS_WIDTH);
                    div_d   = '0;
                    state_d = StData;
                end
            end
            StHold: begin
                if (div_last) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_spi_out.sv
// Scoreboard bench for spi_out: an SPI slave model decodes frames and checks them against
// address/data expectations queued when each frame is launched.
module tb_spi_out;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned CD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_address = '0;
    logic [AW-1:0] word_count = '0;
    logic [DW-1:0] word_data = '0;
    logic          word_valid = 1'b0;
    logic          word_ready, busy, done_strobe, cs, sck, mosi, miso;
`ifdef SPI_OUT_READBACK_EN
    logic [DW-1:0] read_data;
    logic          read_strobe;
`endif

    spi_out #(
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_BUS_WIDTH   (DW),
        .CLK_DIV          (CD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_address(start_address),
        .word_count   (word_count),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .busy         (busy),
        .done_strobe  (done_strobe),
        .cs           (cs),
        .sck          (sck),
        .mosi         (mosi),
        .miso         (miso)
`ifdef SPI_OUT_READBACK_EN
        ,
        .read_data    (read_data),
        .read_strobe  (read_strobe)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] feed[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave model and bus monitor, sampled on the falling clk edge.
    int          s_bits = 0, s_words = 0, words_rx = 0;
    int          cs_low_cnt = 0, last_cs_low = 0, cs_falls = 0, done_cnt = 0;
    int          hi_run = 0, sck_err = 0, rb_cnt = 0;
    logic [15:0] s_sreg = '0, s_addr = '0;
    logic [15:0] rb_word = 16'h1234;
    logic        sck_prev = 1'b0, cs_prev = 1'b1;
    exp_t        mon_e;

    assign miso = (s_bits >= AW) ? rb_word[15 - ((s_bits - AW) % DW)] : 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            s_bits = 0; s_words = 0; hi_run = 0; sck_prev = 1'b0; cs_prev = 1'b1; cs_low_cnt = 0;
        end else begin
            if (cs_prev && !cs) begin
                cs_falls++;
                cs_low_cnt = 0;
            end
            if (!cs) cs_low_cnt++;
            if (!cs_prev && cs) begin
                last_cs_low = cs_low_cnt;
                s_bits = 0;
                s_words = 0;
            end
            if (done_strobe) done_cnt++;
            if (sck) hi_run++;
            if (sck_prev && !sck) begin
                if (hi_run != CD) sck_err++;
                hi_run = 0;
            end
            if (!sck_prev && sck && !cs) begin
                s_sreg = {s_sreg[14:0], mosi};
                s_bits++;
                if (s_bits == AW) begin
                    s_addr = s_sreg;
                end else if (s_bits > AW && ((s_bits - AW) % DW) == 0) begin
                    words_rx++;
                    check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        mon_e = sb.pop_front();
                        check_eq("slave_addr", 32'(s_addr + 16'(s_words)), 32'(mon_e.addr));
                        check_eq("slave_data", 32'(s_sreg), 32'(mon_e.data));
                    end
                    s_words++;
                end
            end
`ifdef SPI_OUT_READBACK_EN
            if (read_strobe) begin
                rb_cnt++;
                check_eq("read_data", 32'(read_data), 32'(rb_word));
            end
`endif
            sck_prev = sck;
            cs_prev  = cs;
        end
    end

    // Word feeder: offers feed[0]; optionally withholds one word while the DUT waits in FETCH.
    int stall_idx = -1, stall_len = 0, stall_cnt = 0, popped = 0, stall_bad = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst || feed.size() == 0) begin
                word_valid = 1'b0;
            end else if (popped == stall_idx && stall_cnt < stall_len) begin
                word_valid = 1'b0;
                if (word_ready) begin
                    stall_cnt++;
                    if (sck || cs) stall_bad++;
                end
            end else begin
                word_data  = feed[0];
                word_valid = 1'b1;
                if (word_ready) begin
                    void'(feed.pop_front());
                    popped++;
                end
            end
        end
    end

    function automatic int exp_cs_low(input int n_words, input int extra);
        return CD + 2 * CD * AW + n_words * (1 + 2 * CD * DW) + CD + extra;
    endfunction

    task automatic launch(input logic [15:0] addr);
        for (int i = 0; i < feed.size(); i++) begin
            exp_t e;
            e.addr = addr + 16'(i);
            e.data = feed[i];
            sb.push_back(e);
        end
        popped    = 0;
        stall_cnt = 0;
        @(negedge clk);
        start         = 1'b1;
        start_address = addr;
        word_count    = 16'(feed.size());
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int seen = 0;
        for (int i = 0; i < max_cycles && seen == 0; i++) begin
            @(negedge clk);
            if (done_strobe) seen = 1;
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    int d0, f0, reached;

    initial begin
        // Reset values while rst is held low.
        repeat (3) @(negedge clk);
        check_eq("rst_cs", 32'(cs), 32'd1);
        check_eq("rst_sck", 32'(sck), 32'd0);
        check_eq("rst_mosi", 32'(mosi), 32'd0);
        check_eq("rst_ready", 32'(word_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done_strobe), 32'd0);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single word, valid held.
        d0 = done_cnt;
        feed = '{16'hBEEF};
        launch(16'h8012);
        repeat (3) @(negedge clk);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_cs_low", 32'(cs), 32'd0);
        wait_done("t1_done", 2000);
        @(negedge clk);
        check_eq("t1_done_1cyc", 32'(done_strobe), 32'd0);
        check_eq("t1_busy_off", 32'(busy), 32'd0);
        check_eq("t1_cs_len", 32'(last_cs_low), 32'(exp_cs_low(1, 0)));
        check_eq("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("t1_sb_empty", 32'(sb.size()), 32'd0);

        // Three words with a 50-cycle stall in front of word 2.
        d0 = done_cnt;
        stall_idx = 1;
        stall_len = 50;
        feed = '{16'h1111, 16'h2222, 16'h3333};
        launch(16'h1FFE);
        wait_done("t2_done", 4000);
        @(negedge clk);
        stall_idx = -1;
        check_eq("t2_stall_len", 32'(stall_cnt), 32'd50);
        check_eq("t2_stall_bus", 32'(stall_bad), 32'd0);
        check_eq("t2_cs_len", 32'(last_cs_low), 32'(exp_cs_low(3, 50)));
        check_eq("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-length request.
        f0 = cs_falls;
        @(negedge clk);
        start = 1'b1;
        start_address = 16'h0055;
        word_count = 16'h0000;
        @(negedge clk);
        start = 1'b0;
        check_eq("t3_done", 32'(done_strobe), 32'd1);
        check_eq("t3_busy", 32'(busy), 32'd0);
        check_eq("t3_cs", 32'(cs), 32'd1);
        @(negedge clk);
        check_eq("t3_done_1cyc", 32'(done_strobe), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("t3_no_cs_fall", 32'(cs_falls - f0), 32'd0);

        // Start re-pulsed mid-frame with different parameters.
        d0 = done_cnt;
        f0 = cs_falls;
        feed = '{16'hA5A5, 16'h0F0F};
        launch(16'h4000);
        repeat (100) @(negedge clk);
        start = 1'b1;
        start_address = 16'h0001;
        word_count = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4_done", 2000);
        repeat (20) @(negedge clk);
        check_eq("t4_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("t4_cs_falls", 32'(cs_falls - f0), 32'd1);
        check_eq("t4_cs_len", 32'(last_cs_low), 32'(exp_cs_low(2, 0)));
        check_eq("t4_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during word 2, bit 7.
        feed = '{16'h1111, 16'h2222, 16'h3333};
        launch(16'h0A0A);
        reached = 0;
        for (int i = 0; i < 3000 && reached == 0; i++) begin
            @(negedge clk);
            if (s_bits == AW + DW + 8) reached = 1;
        end
        check_eq("t5_reached", 32'(reached), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("t5_cs", 32'(cs), 32'd1);
        check_eq("t5_sck", 32'(sck), 32'd0);
        check_eq("t5_mosi", 32'(mosi), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_ready", 32'(word_ready), 32'd0);
        sb.delete();
        feed.delete();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        f0 = cs_falls;
        repeat (100) @(negedge clk);
        check_eq("t5_quiet", 32'(cs_falls - f0), 32'd0);
        check_eq("t5_idle_busy", 32'(busy), 32'd0);
        feed = '{16'h5A5A};
        launch(16'h0123);
        wait_done("t5_new_done", 2000);
        @(negedge clk);
        check_eq("t5_new_cs_len", 32'(last_cs_low), 32'(exp_cs_low(1, 0)));
        check_eq("t5_sb_empty", 32'(sb.size()), 32'd0);

        check_eq("sck_high_len", 32'(sck_err), 32'd0);
`ifdef SPI_OUT_READBACK_EN
        repeat (5) @(negedge clk);
        check_eq("read_strobe_cnt", 32'(rb_cnt), 32'(words_rx));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
